// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Also provides the counter-width helper used by the top.
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [1:0] SEL_RAW  = 2'd0;
  localparam logic [1:0] SEL_CORR = 2'd1;
  localparam logic [1:0] SEL_SYND = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  localparam int MAX_DIGITS = 8;

  // Never returns zero, so a 1-tick phase still gets a real flop.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between the scan controller and its environment: enable, source request,
// digit word in; mux select, nibble, anodes and frame pulse out.
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    en_i;
  logic [1:0]              sel_i;
  logic [4*N_DIGITS-1:0]   digits_i;
  logic [1:0]              e_mux_o;
  logic [3:0]              digit_o;
  logic [N_DIGITS-1:0]     an_o;
  logic                    frame_o;

  modport master (
    output en_i, sel_i, digits_i,
    input  e_mux_o, digit_o, an_o, frame_o
  );

  modport slave (
    input  en_i, sel_i, digits_i,
    output e_mux_o, digit_o, an_o, frame_o
  );
endinterface

// File: rtl/scan_timer.sv
// Terminal-count phase counter: counts 0..limit, then wraps to 0 on its own.
// clr forces it back to 0 and overrides the terminal count.
module scan_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == limit);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan: blank gap then lit phase per digit, all outputs registered.
// The word-mux source select only changes on the wrap from the last digit back to digit 0.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DIG_TICKS   = 27000,
  parameter int BLANK_TICKS = 270
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.slave  bus
);

  localparam int CW = cnt_width(DIG_TICKS, BLANK_TICKS);
  localparam int IW = (N_DIGITS <= 2) ? 1 : $clog2(N_DIGITS);

  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] DIG_LIM   = CW'(DIG_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  scan_state_t         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [3:0]          digit_q, digit_d;
  logic [1:0]          e_mux_q, e_mux_d;
  logic [1:0]          pend_sel_q, pend_sel_d;
  logic                frame_q, frame_d;

  logic [3:0]          nib;
  logic [CW-1:0]       limit;
  logic [CW-1:0]       cnt;
  logic                last;

  assign limit = (state_q == SHOW) ? DIG_LIM : BLANK_LIM;

  scan_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (~bus.en_i),
    .limit (limit),
    .cnt   (cnt),
    .last  (last)
  );

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= limit);

  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib = bus.digits_i[4*k +: 4];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    digit_d    = digit_q;
    e_mux_d    = e_mux_q;
    frame_d    = 1'b0;
    pend_sel_d = (bus.sel_i != SEL_RSVD) ? bus.sel_i : pend_sel_q;

    // Disable overrides a coincident wrap: no pulse and no select update.
    if (!bus.en_i) begin
      state_d = BLANK;
      idx_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          digit_d = nib;
          if (last) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (last) begin
            state_d = BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              frame_d = 1'b1;
              e_mux_d = pend_sel_q;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
      endcase
    end

    for (int k = 0; k < N_DIGITS; k++) begin
      an_d[k] = !((state_d == SHOW) && (idx_d == IW'(k)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      idx_q      <= '0;
      an_q       <= '1;
      digit_q    <= 4'h0;
      e_mux_q    <= SEL_RAW;
      pend_sel_q <= SEL_RAW;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
      e_mux_q    <= e_mux_d;
      pend_sel_q <= pend_sel_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.an_o    = an_q;
  assign bus.digit_o = digit_q;
  assign bus.e_mux_o = e_mux_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: N_DIGITS=4, BLANK_TICKS=2, DIG_TICKS=4 (24-cycle frame).
// "Cycle c" is sampled on the falling edge just before rising edge c; edge 0 is the first after reset.
module tb_display_scan_ctrl;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  display_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  display_scan_ctrl #(
    .N_DIGITS    (4),
    .DIG_TICKS   (4),
    .BLANK_TICKS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected anodes of an uninterrupted scan, c cycles after its start.
  function automatic logic [3:0] exp_an(input int c);
    int p;
    p = c % 24;
    if ((p % 6) < 2) return 4'b1111;
    return ~(4'b0001 << (p / 6));
  endfunction

  task automatic scan_start(input logic [15:0] d);
    rst          = 1'b1;
    bus.en_i     = 1'b1;
    bus.sel_i    = 2'd0;
    bus.digits_i = d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.en_i     = 1'b1;
    bus.sel_i    = 2'd2;
    bus.digits_i = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.an_o !== 4'b1111) $display("FAIL reset_an i=%0d got %b exp 1111", i, bus.an_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.digit_o !== 4'h0) $display("FAIL reset_digit i=%0d got %h exp 0", i, bus.digit_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.e_mux_o !== 2'd0) $display("FAIL reset_emux i=%0d got %0d exp 0", i, bus.e_mux_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.frame_o !== 1'b0) $display("FAIL reset_frame i=%0d got %b exp 0", i, bus.frame_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_scan_order;
    logic [3:0] ed;
    scan_start(16'h4321);
    for (int c = 0; c < 50; c++) begin
      total_cnt++;
      if (bus.an_o !== exp_an(c)) $display("FAIL scan_an c=%0d got %b exp %b", c, bus.an_o, exp_an(c));
      else pass_cnt++;
      total_cnt++;
      if (bus.frame_o !== (c == 24 || c == 48))
        $display("FAIL scan_frame c=%0d got %b exp %b", c, bus.frame_o, (c == 24 || c == 48));
      else pass_cnt++;
      if (exp_an(c) != 4'b1111) begin
        ed = 4'((c % 24) / 6 + 1);
        total_cnt++;
        if (bus.digit_o !== ed) $display("FAIL scan_digit c=%0d got %h exp %h", c, bus.digit_o, ed);
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_source_switch;
    logic [1:0] em;
    scan_start(16'h4321);
    for (int c = 0; c < 30; c++) begin
      em = (c < 24) ? 2'd0 : 2'd2;
      total_cnt++;
      if (bus.e_mux_o !== em) $display("FAIL switch_emux c=%0d got %0d exp %0d", c, bus.e_mux_o, em);
      else pass_cnt++;
      total_cnt++;
      if (bus.frame_o !== (c == 24)) $display("FAIL switch_frame c=%0d got %b exp %b", c, bus.frame_o, (c == 24));
      else pass_cnt++;
      if (c == 10) bus.sel_i = 2'd2;
      @(negedge clk);
    end
  endtask

  task automatic test_reserved_sel;
    scan_start(16'h4321);
    for (int c = 0; c < 26; c++) begin
      if (c == 23 || c == 24 || c == 25) begin
        total_cnt++;
        if (bus.e_mux_o !== ((c == 23) ? 2'd0 : 2'd1))
          $display("FAIL rsvd_emux c=%0d got %0d exp %0d", c, bus.e_mux_o, (c == 23) ? 2'd0 : 2'd1);
        else pass_cnt++;
      end
      if (c == 3) bus.sel_i = 2'd1;
      if (c == 5) bus.sel_i = 2'd3;
      @(negedge clk);
    end
  endtask

  task automatic test_enable_drop;
    scan_start(16'h4321);
    bus.sel_i = 2'd1;
    for (int c = 0; c < 16; c++) begin
      if (c == 9) begin
        total_cnt++;
        if (bus.an_o !== 4'b1101) $display("FAIL drop_pre_an got %b exp 1101", bus.an_o);
        else pass_cnt++;
      end
      if (c >= 10 && c <= 13) begin
        total_cnt++;
        if (bus.an_o !== 4'b1111) $display("FAIL drop_blank_an c=%0d got %b exp 1111", c, bus.an_o);
        else pass_cnt++;
      end
      if (c == 14) begin
        total_cnt++;
        if (bus.an_o !== 4'b1110) $display("FAIL drop_resume_an got %b exp 1110", bus.an_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.digit_o !== 4'h1) $display("FAIL drop_resume_digit got %h exp 1", bus.digit_o);
        else pass_cnt++;
      end
      total_cnt++;
      if (bus.frame_o !== 1'b0) $display("FAIL drop_frame c=%0d got %b exp 0", c, bus.frame_o);
      else pass_cnt++;
      if (c == 9)  bus.en_i = 1'b0;
      if (c == 12) bus.en_i = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_drop_on_wrap;
    scan_start(16'h4321);
    bus.sel_i = 2'd2;
    for (int c = 0; c < 51; c++) begin
      if (c == 24) begin
        total_cnt++;
        if (bus.frame_o !== 1'b0) $display("FAIL wrapdrop_frame got %b exp 0", bus.frame_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.e_mux_o !== 2'd0) $display("FAIL wrapdrop_emux got %0d exp 0", bus.e_mux_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.an_o !== 4'b1111) $display("FAIL wrapdrop_an got %b exp 1111", bus.an_o);
        else pass_cnt++;
      end
      if (c == 49) begin
        total_cnt++;
        if (bus.frame_o !== 1'b1) $display("FAIL wrapdrop_refr got %b exp 1", bus.frame_o);
        else pass_cnt++;
      end
      if (c == 50) begin
        total_cnt++;
        if (bus.e_mux_o !== 2'd2) $display("FAIL wrapdrop_kept got %0d exp 2", bus.e_mux_o);
        else pass_cnt++;
      end
      if (c == 23) bus.en_i = 1'b0;
      if (c == 25) bus.en_i = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset;
    scan_start(16'h4321);
    bus.sel_i = 2'd1;
    for (int c = 0; c < 66; c++) begin
      if (c == 39) begin
        total_cnt++;
        if (bus.an_o !== 4'b1011 || bus.e_mux_o !== 2'd1)
          $display("FAIL mrst_pre got an=%b emux=%0d exp an=1011 emux=1", bus.an_o, bus.e_mux_o);
        else pass_cnt++;
      end
      if (c == 40) begin
        total_cnt++;
        if (bus.an_o !== 4'b1111) $display("FAIL mrst_an got %b exp 1111", bus.an_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.digit_o !== 4'h0) $display("FAIL mrst_digit got %h exp 0", bus.digit_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.e_mux_o !== 2'd0) $display("FAIL mrst_emux got %0d exp 0", bus.e_mux_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.frame_o !== 1'b0) $display("FAIL mrst_frame got %b exp 0", bus.frame_o);
        else pass_cnt++;
      end
      if (c == 64 || c == 65) begin
        total_cnt++;
        if (bus.frame_o !== (c == 64)) $display("FAIL mrst_refr c=%0d got %b exp %b", c, bus.frame_o, (c == 64));
        else pass_cnt++;
        total_cnt++;
        if (bus.e_mux_o !== 2'd0) $display("FAIL mrst_pend c=%0d got %0d exp 0", c, bus.e_mux_o);
        else pass_cnt++;
      end
      if (c == 39) begin
        rst       = 1'b1;
        bus.sel_i = 2'd3;
      end
      if (c == 40) rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_digit_hold;
    logic [3:0] ed;
    scan_start(16'h4321);
    for (int c = 0; c < 21; c++) begin
      if (c >= 14) begin
        ed = (c <= 18) ? 4'h3 : 4'h8;
        total_cnt++;
        if (bus.digit_o !== ed) $display("FAIL hold_digit c=%0d got %h exp %h", c, bus.digit_o, ed);
        else pass_cnt++;
      end
      if (c == 20) begin
        total_cnt++;
        if (bus.an_o !== 4'b0111) $display("FAIL hold_an got %b exp 0111", bus.an_o);
        else pass_cnt++;
      end
      if (c == 14) bus.digits_i = 16'h8765;
      @(negedge clk);
    end
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst          = 1'b1;
    bus.en_i     = 1'b0;
    bus.sel_i    = 2'd0;
    bus.digits_i = 16'h0;
    @(negedge clk);
    test_reset();
    test_scan_order();
    test_source_switch();
    test_reserved_sel();
    test_enable_drop();
    test_drop_on_wrap();
    test_mid_reset();
    test_digit_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the shared 7-segment display path. It steps through N_DIGITS nibbles and presents one nibble at a time to the hex-to-segment decoder. It drives the active-low anode enables, inserting a blanking gap between digits to suppress ghosting. It also owns the source-select of the upstream word mux (raw / corrected / syndrome) and switches it only at frame boundaries, so a displayed frame never mixes sources.

Parameters:
N_DIGITS, 4, number of scanned digits (2..8).
DIG_TICKS, 27000, clk cycles each digit is lit (>=1).
BLANK_TICKS, 270, clk cycles all anodes are off before each digit (>=1).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
en_i  in  1  scan enable; low forces blanking and restarts the scan.
sel_i  in  2  requested mux source; 0..2 valid, 3 reserved.
digits_i  in  4*N_DIGITS  packed nibbles; digit k = bits [4k+3:4k].
e_mux_o  out  2  source select to the word mux.
digit_o  out  4  nibble to the segment decoder.
an_o  out  N_DIGITS  anode enables, active-low, one-hot-low when lit.
frame_o  out  1  one-cycle pulse marking the frame boundary.

Behaviour:
- Reset, and on every clk edge with rst=1: state=BLANK, idx=0, cnt=0, an_o all 1, digit_o=0, e_mux_o=0, pend_sel=0, frame_o=0. Reset takes precedence over everything.
- All outputs are registered.
- FSM states:
  - BLANK: an_o all 1. digit_o <= digits_i[idx] every cycle. cnt counts 0..BLANK_TICKS-1. On the last count: cnt<=0, go to SHOW.
  - SHOW: an_o[idx]=0, all other anodes 1. digit_o frozen. cnt counts 0..DIG_TICKS-1. On the last count: cnt<=0, go to BLANK. idx <= idx+1, or 0 when idx==N_DIGITS-1 (wrap).
- Frame boundary is the wrap transition. On that edge: e_mux_o <= pend_sel and frame_o <= 1 for exactly one cycle.
- Frame length: N_DIGITS*(BLANK_TICKS+DIG_TICKS) cycles.
- sel_i handling:
  - sel_i is sampled every cycle into pend_sel when sel_i != 3.
  - sel_i==3 is ignored; pend_sel is unchanged.
  - The last valid value before the boundary wins.
- Changes on digits_i during SHOW do not affect digit_o until the next BLANK.
- en_i=0, at the next edge: state=BLANK, idx=0, cnt=0, an_o all 1, frame_o=0. e_mux_o and pend_sel are kept. Scan restarts at digit 0 BLANK on the first edge with en_i=1.
- If en_i falls on the same edge as a wrap: en_i wins. No frame_o pulse, no e_mux_o update.
- Counter width is $clog2(max(DIG_TICKS,BLANK_TICKS)). There must be no overflow path: cnt is always cleared at the terminal count.

Decomposition:
- Package display_pkg:
  - scan_state_t enum {BLANK, SHOW}.
  - SEL_RAW=2'd0, SEL_CORR=2'd1, SEL_SYND=2'd2, SEL_RSVD=2'd3.
  - MAX_DIGITS=8.
- One sub-module: scan_timer.
  - Loadable terminal-count counter.
  - Inputs: clk, rst, clr, limit.
  - Outputs: cnt, last.
  - Instantiated once; limit is muxed from BLANK_TICKS or DIG_TICKS by state.
- Nibble selection and anode decode stay in display_scan_ctrl.

Test Plan:
All scenarios use N_DIGITS=4, BLANK_TICKS=2, DIG_TICKS=4 (frame = 24 cycles); cycle 0 = first edge after rst deasserts, en_i=1.
1. Reset: rst=1 for 3 cycles -> an_o=4'b1111, digit_o=0, e_mux_o=0, frame_o=0 throughout.
2. Scan order: digits_i=16'h4321 -> an_o 1111 x2, 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4. digit_o=1,2,3,4 during the respective SHOWs. frame_o high only at cycle 24, then the pattern repeats.
3. Source switch: sel_i=2 from cycle 10 -> e_mux_o=0 until cycle 24, then 2; frame_o=1 on that same cycle.
4. Reserved select: sel_i=1 at cycle 3, then sel_i=3 from cycle 5 -> e_mux_o=1 at cycle 24.
5. Enable drop: en_i=0 at cycle 9 (digit 1 SHOW) for 3 cycles -> an_o=1111 from the next cycle. After re-enable: 2 blank cycles, then an_o=1110 with digit_o=1.
6. Mid-operation reset and digit stability: rst pulsed during digit 2 SHOW -> all outputs at reset values on the next edge. Separately, digits_i changed during digit 2 SHOW -> digit_o holds 3 until the following BLANK.
